// File: rtl/icb_master_arb.sv
// N-channel ICB master arbiter: merges client command streams onto one ICB port
// and routes in-order responses back through a channel-ID FIFO.
module icb_master_arb #(
  parameter int NCH        = 3,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 4,
  parameter int ARB_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          biu_cmd_vld,
  output logic [NCH-1:0]          biu_cmd_rdy,
  input  logic [NCH*AW-1:0]       biu_cmd_addr,
  input  logic [NCH-1:0]          biu_cmd_read,
  input  logic [NCH*DW-1:0]       biu_cmd_wdata,
  input  logic [NCH*(DW/8)-1:0]   biu_cmd_wmask,
  input  logic [NCH-1:0]          biu_cmd_lock,
  output logic [NCH-1:0]          biu_rsp_vld,
  input  logic [NCH-1:0]          biu_rsp_rdy,
  output logic [DW-1:0]           biu_rsp_data,
  output logic                    biu_rsp_err,
  output logic                    icb_cmd_valid,
  input  logic                    icb_cmd_ready,
  output logic [AW-1:0]           icb_cmd_addr,
  output logic                    icb_cmd_read,
  output logic [DW-1:0]           icb_cmd_wdata,
  output logic [DW/8-1:0]         icb_cmd_wmask,
  input  logic                    icb_rsp_valid,
  output logic                    icb_rsp_ready,
  input  logic                    icb_rsp_err,
  input  logic [DW-1:0]           icb_rsp_rdata
);
  // Handshakes: a beat transfers on the cycle where valid and ready are both high;
  // ready may be presented without valid, and nothing is registered on the command path.
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH + 1);
  localparam int MW = DW / 8;

  logic [IW-1:0] id_mem [OUTS_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lock_owner;
  logic          lock_q;

  logic [IW-1:0] winner;
  logic          win_any;
  logic          win_vld;
  logic          full;
  logic          not_empty;
  logic [IW-1:0] head;
  logic          cmd_hs;
  logic          rsp_hs;
  int            idx;

  // Scan in reverse so the last match written is the first in priority order.
  always_comb begin
    winner  = '0;
    win_any = 1'b0;
    idx     = 0;
    if (lock_q) begin
      winner  = lock_owner;
      win_any = 1'b1;
    end else if (ARB_MODE == 0) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (biu_cmd_vld[i]) begin
          winner  = IW'(i);
          win_any = 1'b1;
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (biu_cmd_vld[idx]) begin
          winner  = IW'(idx);
          win_any = 1'b1;
        end
      end
    end
  end

  assign win_vld   = win_any & biu_cmd_vld[winner];
  assign full      = (count == CW'(OUTS_DEPTH));
  assign not_empty = (count != '0);
  assign head      = id_mem[rd_ptr];

  always_comb begin
    icb_cmd_valid = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_read  = 1'b0;
    icb_cmd_wdata = '0;
    icb_cmd_wmask = '0;
    biu_cmd_rdy   = '0;
    if (rst_n) begin
      if (win_vld) begin
        icb_cmd_valid = !full;
        icb_cmd_addr  = biu_cmd_addr[int'(winner)*AW +: AW];
        icb_cmd_read  = biu_cmd_read[winner];
        icb_cmd_wdata = biu_cmd_wdata[int'(winner)*DW +: DW];
        icb_cmd_wmask = biu_cmd_wmask[int'(winner)*MW +: MW];
      end
      if (win_any) biu_cmd_rdy[winner] = icb_cmd_ready & !full;
    end
  end

  // Response data is passed straight through; only valid/ready are steered by the head ID.
  always_comb begin
    biu_rsp_vld   = '0;
    icb_rsp_ready = 1'b0;
    biu_rsp_data  = '0;
    biu_rsp_err   = 1'b0;
    if (rst_n) begin
      biu_rsp_data = icb_rsp_rdata;
      biu_rsp_err  = icb_rsp_err;
      if (not_empty) begin
        biu_rsp_vld[head] = icb_rsp_valid;
        icb_rsp_ready     = biu_rsp_rdy[head];
      end
    end
  end

  assign cmd_hs = icb_cmd_valid & icb_cmd_ready;
  assign rsp_hs = icb_rsp_valid & icb_rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      lock_q     <= 1'b0;
      lock_owner <= '0;
    end else begin
      if (cmd_hs) begin
        wr_ptr     <= (wr_ptr == PW'(OUTS_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        lock_q     <= biu_cmd_lock[winner];
        lock_owner <= winner;
        if (ARB_MODE != 0) rr_ptr <= (winner == IW'(NCH - 1)) ? '0 : winner + 1'b1;
      end
      if (rsp_hs) rd_ptr <= (rd_ptr == PW'(OUTS_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({cmd_hs, rsp_hs})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_hs) id_mem[wr_ptr] <= winner;
  end

endmodule

// File: tb/tb_icb_master_arb.sv
// Bench for icb_master_arb: one fixed-priority and one round-robin instance share random
// stimulus; each lane has its own transaction-level model, expected queues and monitor.
module tb_icb_master_arb;
  localparam int NCH   = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int SW    = 1 + NCH + 1 + NCH + AW + 1 + DW + MW + DW + 1;
  localparam int CMW   = 3 + 1 + AW + DW + MW;
  localparam int RW    = 3 + 1 + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    biu_cmd_vld;
  logic [NCH-1:0]    biu_cmd_read;
  logic [NCH-1:0]    biu_cmd_lock;
  logic [NCH-1:0]    biu_rsp_rdy;
  logic [NCH*AW-1:0] biu_cmd_addr;
  logic [NCH*DW-1:0] biu_cmd_wdata;
  logic [NCH*MW-1:0] biu_cmd_wmask;
  logic              icb_cmd_ready;
  logic              icb_rsp_valid;
  logic              icb_rsp_err;
  logic [DW-1:0]     icb_rsp_rdata;

  int compared = 0;
  int mismatched = 0;
  bit run = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : lane
    logic [NCH-1:0] cmd_rdy;
    logic [NCH-1:0] rsp_vld;
    logic           cmd_valid;
    logic           cmd_read;
    logic           rsp_ready;
    logic           rsp_err;
    logic [AW-1:0]  cmd_addr;
    logic [DW-1:0]  cmd_wdata;
    logic [DW-1:0]  rsp_data;
    logic [MW-1:0]  cmd_wmask;

    icb_master_arb #(
      .NCH(NCH), .AW(AW), .DW(DW), .OUTS_DEPTH(DEPTH), .ARB_MODE(g)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .biu_cmd_vld(biu_cmd_vld), .biu_cmd_rdy(cmd_rdy),
      .biu_cmd_addr(biu_cmd_addr), .biu_cmd_read(biu_cmd_read),
      .biu_cmd_wdata(biu_cmd_wdata), .biu_cmd_wmask(biu_cmd_wmask),
      .biu_cmd_lock(biu_cmd_lock),
      .biu_rsp_vld(rsp_vld), .biu_rsp_rdy(biu_rsp_rdy),
      .biu_rsp_data(rsp_data), .biu_rsp_err(rsp_err),
      .icb_cmd_valid(cmd_valid), .icb_cmd_ready(icb_cmd_ready),
      .icb_cmd_addr(cmd_addr), .icb_cmd_read(cmd_read),
      .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
      .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(rsp_ready),
      .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata)
    );

    logic [SW-1:0]  st_q[$];
    logic [CMW-1:0] cmd_q[$];
    logic [RW-1:0]  rsp_q[$];

    // Reference state: owner queue of issued commands, pointer, lock.
    int owners[$];
    int rr, lk, own, w, h, c, gc;
    logic          e_cv, e_rr, e_read, cmd_hs, rsp_hs;
    logic [NCH-1:0] e_rdy, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    logic [MW-1:0] e_wm;
    logic          e_err;
    logic [SW-1:0]  e_st, g_st;
    logic [CMW-1:0] e_cmd, g_cmd;
    logic [RW-1:0]  e_rsp, g_rsp;

    always @(negedge clk) if (run) begin
      #1;
      e_cv = 1'b0; e_rdy = '0; e_rr = 1'b0; e_rv = '0; e_addr = '0; e_read = 1'b0;
      e_wd = '0; e_wm = '0; e_rd = '0; e_err = 1'b0; cmd_hs = 1'b0; rsp_hs = 1'b0;
      w = -1; h = 0;
      if (!rst_n) begin
        rr = 0; lk = 0; own = 0; owners.delete();
      end else begin
        if (lk != 0) w = own;
        else
          for (int k = 0; k < NCH; k++) begin
            c = (g == 1) ? (rr + k) % NCH : k;
            if (w < 0 && biu_cmd_vld[c]) w = c;
          end
        if (w >= 0) begin
          if (biu_cmd_vld[w]) begin
            e_cv   = (owners.size() < DEPTH);
            e_addr = biu_cmd_addr[w*AW +: AW];
            e_read = biu_cmd_read[w];
            e_wd   = biu_cmd_wdata[w*DW +: DW];
            e_wm   = biu_cmd_wmask[w*MW +: MW];
          end
          e_rdy[w] = icb_cmd_ready && (owners.size() < DEPTH);
        end
        if (owners.size() > 0) begin
          h = owners[0];
          e_rr = biu_rsp_rdy[h];
          e_rv[h] = icb_rsp_valid;
        end
        e_rd  = icb_rsp_rdata;
        e_err = icb_rsp_err;
        cmd_hs = e_cv && icb_cmd_ready;
        rsp_hs = icb_rsp_valid && e_rr;
      end
      st_q.push_back({e_cv, e_rdy, e_rr, e_rv, e_addr, e_read, e_wd, e_wm, e_rd, e_err});
      if (cmd_hs) begin
        cmd_q.push_back({3'(w), e_read, e_addr, e_wd, e_wm});
        if (g == 1) rr = (w + 1) % NCH;
        lk  = int'(biu_cmd_lock[w]);
        own = w;
      end
      if (rsp_hs) begin
        rsp_q.push_back({3'(h), icb_rsp_err, icb_rsp_rdata});
        void'(owners.pop_front());
      end
      if (cmd_hs) owners.push_back(w);
    end

    always @(negedge clk) if (run) begin
      #2;
      g_st = {cmd_valid, cmd_rdy, rsp_ready, rsp_vld, cmd_addr, cmd_read, cmd_wdata,
              cmd_wmask, rsp_data, rsp_err};
      compared++;
      if (st_q.size() == 0) begin
        mismatched++;
        $display("FAIL lane%0d status: no expectation queued, got %h", g, g_st);
      end else begin
        e_st = st_q.pop_front();
        if (g_st !== e_st) begin
          mismatched++;
          $display("FAIL lane%0d status @%0t: got %h expected %h", g, $time, g_st, e_st);
        end
      end
      if (cmd_valid === 1'b1 && icb_cmd_ready) begin
        gc = 7;
        for (int k = 0; k < NCH; k++) if (cmd_rdy[k]) gc = k;
        g_cmd = {3'(gc), cmd_read, cmd_addr, cmd_wdata, cmd_wmask};
        compared++;
        if (cmd_q.size() == 0) begin
          mismatched++;
          $display("FAIL lane%0d cmd: unexpected issue %h", g, g_cmd);
        end else begin
          e_cmd = cmd_q.pop_front();
          if (g_cmd !== e_cmd) begin
            mismatched++;
            $display("FAIL lane%0d cmd @%0t: got %h expected %h", g, $time, g_cmd, e_cmd);
          end
        end
      end
      for (int k = 0; k < NCH; k++) begin
        if (rsp_vld[k] === 1'b1 && biu_rsp_rdy[k]) begin
          g_rsp = {3'(k), rsp_err, rsp_data};
          compared++;
          if (rsp_q.size() == 0) begin
            mismatched++;
            $display("FAIL lane%0d rsp: unexpected response %h", g, g_rsp);
          end else begin
            e_rsp = rsp_q.pop_front();
            if (g_rsp !== e_rsp) begin
              mismatched++;
              $display("FAIL lane%0d rsp @%0t: got %h expected %h", g, $time, g_rsp, e_rsp);
            end
          end
        end
      end
      compared++;
      if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
        mismatched++;
        $display("FAIL lane%0d missing handshake @%0t: got cmd_left=%0d rsp_left=%0d expected 0",
                 g, $time, cmd_q.size(), rsp_q.size());
        cmd_q.delete();
        rsp_q.delete();
      end
    end
  end

  // Percent knobs: command valid, lock, icb ready, icb response valid, client response ready.
  task automatic cycle(input bit rst, input int vp, input int lp, input int cp,
                       input int rvp, input int rrp);
    @(negedge clk);
    rst_n = !rst;
    for (int c = 0; c < NCH; c++) begin
      biu_cmd_vld[c]  = ($urandom_range(99, 0) < vp);
      biu_cmd_lock[c] = ($urandom_range(99, 0) < lp);
      biu_cmd_read[c] = 1'($urandom_range(1, 0));
      biu_cmd_addr[c*AW +: AW]  = $urandom;
      biu_cmd_wdata[c*DW +: DW] = $urandom;
      biu_cmd_wmask[c*MW +: MW] = MW'($urandom);
      biu_rsp_rdy[c]  = ($urandom_range(99, 0) < rrp);
    end
    icb_cmd_ready = ($urandom_range(99, 0) < cp);
    icb_rsp_valid = ($urandom_range(99, 0) < rvp);
    icb_rsp_err   = ($urandom_range(9, 0) == 0);
    icb_rsp_rdata = $urandom;
  endtask

  initial begin
    biu_cmd_vld = '0; biu_cmd_read = '0; biu_cmd_lock = '0; biu_rsp_rdy = '0;
    biu_cmd_addr = '0; biu_cmd_wdata = '0; biu_cmd_wmask = '0;
    icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0; icb_rsp_rdata = '0;
    run = 1'b1;
    repeat (3)   cycle(1'b1, 60, 30, 80, 50, 80);
    repeat (400) cycle(1'b0, 60, 25, 75, 60, 80);
    repeat (30)  cycle(1'b0, 100, 0, 100, 100, 100);
    repeat (10)  cycle(1'b0, 100, 0, 100, 0, 100);
    repeat (3)   cycle(1'b0, 100, 0, 100, 100, 100);
    repeat (200) cycle(1'b0, 50, 70, 80, 50, 70);
    repeat (4)   cycle(1'b0, 100, 0, 100, 0, 100);
    cycle(1'b1, 0, 0, 100, 0, 100);
    repeat (4)   cycle(1'b0, 0, 0, 100, 100, 100);
    repeat (300) cycle(1'b0, 60, 25, 75, 60, 80);
    #3;
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
